// File: rtl/rob_commit_unit.sv
// Reorder buffer: hands out tags, captures CDB results, retires in order.
// Ports: alloc_* (dispatch), cdb_* (result bus), commit_* (write-back), clr/redirect_pc (flush).
module rob_commit_unit #(
   parameter int DEPTH  = 32,
   parameter int TAG_W  = 5,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              alloc_valid,
   input  logic [REG_W-1:0]  alloc_rd,
   output logic [TAG_W-1:0]  alloc_tag,
   output logic              alloc_ready,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_value,
   input  logic              cdb_mispredict,
   input  logic [DATA_W-1:0] cdb_target,
   output logic              commit_valid,
   output logic [REG_W-1:0]  commit_rd,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [DATA_W-1:0] commit_value,
   output logic              clr,
   output logic [DATA_W-1:0] redirect_pc
);

   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [DEPTH-1:0]  ready_q, ready_d;
   logic [DEPTH-1:0]  mis_q, mis_d;
   logic [REG_W-1:0]  rd_q [DEPTH];
   logic [REG_W-1:0]  rd_d [DEPTH];
   logic [DATA_W-1:0] value_q [DEPTH];
   logic [DATA_W-1:0] value_d [DEPTH];
   logic [DATA_W-1:0] target_q [DEPTH];
   logic [DATA_W-1:0] target_d [DEPTH];

   logic [TAG_W-1:0]  head_q, head_d;
   logic [TAG_W-1:0]  tail_q, tail_d;
   logic [TAG_W:0]    count_q, count_d;

   logic              commit_valid_q, commit_valid_d;
   logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
   logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
   logic [DATA_W-1:0] commit_value_q, commit_value_d;
   logic              clr_q, clr_d;
   logic [DATA_W-1:0] redirect_q, redirect_d;

   logic commit_go;
   logic flush;
   logic do_alloc;
   logic do_cdb;

   assign alloc_tag    = tail_q;
   assign alloc_ready  = (count_q != FULL_CNT) && !clr_q;
   assign commit_valid = commit_valid_q;
   assign commit_rd    = commit_rd_q;
   assign commit_tag   = commit_tag_q;
   assign commit_value = commit_value_q;
   assign clr          = clr_q;
   assign redirect_pc  = redirect_q;

   // Retirement looks only at registered entry state, so a result that
   // lands on the head this cycle retires on the following one.
   assign commit_go = rdy && busy_q[head_q] && ready_q[head_q];
   assign flush     = commit_go && mis_q[head_q];
   assign do_alloc  = rdy && alloc_valid && alloc_ready && !flush;
   assign do_cdb    = rdy && cdb_valid && !clr_q && !flush
                      && busy_q[cdb_tag];

   always_comb begin
      busy_d   = busy_q;
      ready_d  = ready_q;
      mis_d    = mis_q;
      rd_d     = rd_q;
      value_d  = value_q;
      target_d = target_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;

      commit_valid_d = commit_go;
      commit_rd_d    = commit_rd_q;
      commit_tag_d   = commit_tag_q;
      commit_value_d = commit_value_q;
      clr_d          = flush;
      redirect_d     = redirect_q;

      if (do_cdb) begin
         ready_d[cdb_tag]  = 1'b1;
         value_d[cdb_tag]  = cdb_value;
         mis_d[cdb_tag]    = cdb_mispredict;
         target_d[cdb_tag] = cdb_target;
      end

      if (commit_go) begin
         commit_rd_d    = rd_q[head_q];
         commit_tag_d   = head_q;
         commit_value_d = value_q[head_q];
         busy_d[head_q] = 1'b0;
         head_d         = head_q + 1'b1;
      end

      // The tail slot can never be the committing head here: that would
      // need a full buffer, which already blocks allocation.
      if (do_alloc) begin
         busy_d[tail_q]  = 1'b1;
         ready_d[tail_q] = 1'b0;
         mis_d[tail_q]   = 1'b0;
         rd_d[tail_q]    = alloc_rd;
         tail_d          = tail_q + 1'b1;
      end

      unique case ({do_alloc, commit_go})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (flush) begin
         redirect_d = target_q[head_q];
         busy_d     = '0;
         ready_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q         <= '0;
         ready_q        <= '0;
         mis_q          <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_rd_q    <= '0;
         commit_tag_q   <= '0;
         commit_value_q <= '0;
         clr_q          <= 1'b0;
         redirect_q     <= '0;
      end else begin
         busy_q         <= busy_d;
         ready_q        <= ready_d;
         mis_q          <= mis_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_rd_q    <= commit_rd_d;
         commit_tag_q   <= commit_tag_d;
         commit_value_q <= commit_value_d;
         clr_q          <= clr_d;
         redirect_q     <= redirect_d;
      end
   end

   // Payload is only read behind busy/ready, so it needs no reset.
   always_ff @(posedge clk) begin
      rd_q     <= rd_d;
      value_q  <= value_d;
      target_q <= target_d;
   end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: program-order queue model,
// expected retirements queued by the driver and checked by a monitor.
module tb_rob_commit_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b0;
   logic        alloc_valid = 1'b0;
   logic [4:0]  alloc_rd = '0;
   logic [4:0]  alloc_tag;
   logic        alloc_ready;
   logic        cdb_valid = 1'b0;
   logic [4:0]  cdb_tag = '0;
   logic [31:0] cdb_value = '0;
   logic        cdb_mispredict = 1'b0;
   logic [31:0] cdb_target = '0;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [4:0]  commit_tag;
   logic [31:0] commit_value;
   logic        clr;
   logic [31:0] redirect_pc;

   rob_commit_unit dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .alloc_tag(alloc_tag), .alloc_ready(alloc_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
      .commit_valid(commit_valid), .commit_rd(commit_rd),
      .commit_tag(commit_tag), .commit_value(commit_value),
      .clr(clr), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct {
      int          tag;
      logic [4:0]  rd;
      bit          done;
      logic [31:0] value;
      bit          mis;
      logic [31:0] target;
   } ent_t;

   typedef struct {
      int          at;
      logic [4:0]  rd;
      logic [4:0]  tag;
      logic [31:0] value;
      bit          clr;
      logic [31:0] pc;
   } exp_t;

   ent_t rob[$];
   exp_t expq[$];
   int   next_tag = 0;
   bit   m_clr = 0;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus: check the combinational alloc outputs against
   // the model, drive inputs, advance the model, queue any retirement.
   task automatic cyc(input bit r, input bit av, input logic [4:0] ard,
                      input bit cv, input logic [4:0] ctag,
                      input logic [31:0] cval, input bit cmis,
                      input logic [31:0] ctgt);
      bit   go;
      bit   fl;
      ent_t h;
      exp_t e;
      @(negedge clk);
      chk("alloc_tag", 64'(alloc_tag), 64'(next_tag));
      chk("alloc_ready", 64'(alloc_ready),
          64'(rob.size() < 32 && !m_clr));
      rdy = r; alloc_valid = av; alloc_rd = ard;
      cdb_valid = cv; cdb_tag = ctag; cdb_value = cval;
      cdb_mispredict = cmis; cdb_target = ctgt;
      if (!r) begin
         m_clr = 0;
      end else begin
         go = rob.size() > 0 && rob[0].done;
         fl = 0;
         if (go) begin
            h = rob[0];
            fl = h.mis;
            e.at = edge_n + 1; e.rd = h.rd; e.tag = 5'(h.tag);
            e.value = h.value; e.clr = h.mis; e.pc = h.target;
            expq.push_back(e);
         end
         if (fl) begin
            rob.delete();
            next_tag = 0;
         end else begin
            if (cv && !m_clr)
               foreach (rob[i])
                  if (rob[i].tag == int'(ctag)) begin
                     rob[i].done = 1; rob[i].value = cval;
                     rob[i].mis = cmis; rob[i].target = ctgt;
                  end
            if (go) void'(rob.pop_front());
            if (av && !m_clr && rob.size() < 32 + (go ? 1 : 0)
                && (rob.size() + (go ? 1 : 0)) < 32) begin
               h.tag = next_tag; h.rd = ard; h.done = 0;
               h.value = '0; h.mis = 0; h.target = '0;
               rob.push_back(h);
               next_tag = (next_tag + 1) % 32;
            end
         end
         m_clr = fl;
      end
      @(posedge clk);
   endtask

   task automatic idle();
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic alloc(input logic [4:0] rd);
      cyc(1, 1, rd, 0, 0, 0, 0, 0);
   endtask

   task automatic cdb(input logic [4:0] t, input logic [31:0] v,
                      input bit m, input logic [31:0] tg);
      cyc(1, 0, 0, 1, t, v, m, tg);
   endtask

   task automatic do_reset(input bit chk_out);
      @(negedge clk);
      #2 rst = 1;
      alloc_valid = 0; cdb_valid = 0;
      #1;
      if (chk_out) begin
         chk("rst_commit_valid", 64'(commit_valid), 0);
         chk("rst_clr", 64'(clr), 0);
         chk("rst_commit_rd", 64'(commit_rd), 0);
         chk("rst_commit_tag", 64'(commit_tag), 0);
         chk("rst_commit_value", 64'(commit_value), 0);
         chk("rst_redirect", 64'(redirect_pc), 0);
         chk("rst_alloc_tag", 64'(alloc_tag), 0);
         chk("rst_alloc_ready", 64'(alloc_ready), 1);
      end
      rob.delete();
      next_tag = 0;
      m_clr = 0;
      @(negedge clk);
      rst = 0;
   endtask

   // Monitor: independent of the driver, pops an expectation whenever
   // the DUT retires something.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (commit_valid) begin
            if (expq.size() == 0) begin
               chk("unexpected_commit", 64'(commit_tag), 64'h3f);
            end else begin
               e = expq.pop_front();
               chk("commit_edge", 64'(edge_n), 64'(e.at));
               chk("commit_tag", 64'(commit_tag), 64'(e.tag));
               chk("commit_rd", 64'(commit_rd), 64'(e.rd));
               chk("commit_value", 64'(commit_value), 64'(e.value));
               chk("commit_clr", 64'(clr), 64'(e.clr));
               if (e.clr) chk("redirect_pc", 64'(redirect_pc), 64'(e.pc));
            end
         end else if (clr) begin
            chk("clr_without_commit", 64'(clr), 0);
         end
         if (expq.size() > 0 && expq[0].at < edge_n)
            chk("missed_commit", 64'(expq.pop_front().at), 64'(edge_n));
      end
   end

   initial begin
      int idx;
      bit r, av, cv, cm;
      logic [4:0] ard, ctag;

      // Reset state
      rst = 1;
      #12;
      chk("init_commit_valid", 64'(commit_valid), 0);
      chk("init_clr", 64'(clr), 0);
      chk("init_alloc_tag", 64'(alloc_tag), 0);
      rst = 0;

      // In-order retirement despite out-of-order results
      do_reset(1);
      alloc(3); alloc(5); alloc(7);
      cdb(1, 32'h11, 0, 0);
      cdb(0, 32'h10, 0, 0);
      cdb(2, 32'h12, 0, 0);
      repeat (4) idle();

      // Fill to full, ignored 33rd request, then wrap-around
      do_reset(0);
      for (int i = 0; i < 33; i++) alloc(5'($urandom_range(31)));
      cdb(0, 32'hA0, 0, 0);
      cyc(1, 1, 9, 1, 1, 32'hA1, 0, 0);
      cyc(1, 1, 10, 0, 0, 0, 0, 0);
      cyc(1, 1, 11, 0, 0, 0, 0, 0);
      repeat (2) idle();

      // rd=0 still retires
      do_reset(0);
      alloc(0);
      cdb(0, 32'hFF, 0, 0);
      repeat (3) idle();

      // Mispredict flush
      do_reset(0);
      for (int i = 1; i <= 5; i++) alloc(5'(i));
      cdb(0, 32'h100, 0, 0);
      cdb(1, 32'h101, 1, 32'h1000);
      cdb(3, 32'h103, 0, 0);
      cyc(1, 1, 4, 1, 3, 32'h55, 0, 0);
      repeat (4) idle();

      // Frozen by rdy=0
      do_reset(0);
      alloc(6);
      cdb(0, 32'h66, 0, 0);
      repeat (3) cyc(0, 1, 8, 1, 0, 32'h77, 0, 0);
      repeat (3) idle();

      // Async reset while busy and retiring
      do_reset(0);
      for (int i = 0; i < 10; i++) alloc(5'(i + 1));
      cdb(0, 32'h5A, 0, 0);
      idle();
      do_reset(1);
      idle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(9) != 0);
         av = ($urandom_range(3) != 0);
         ard = 5'($urandom_range(31));
         cv = 0;
         ctag = 5'($urandom_range(31));
         if (rob.size() > 0 && $urandom_range(2) != 0) begin
            idx = $urandom_range(rob.size() - 1);
            ctag = 5'(rob[idx].tag);
            cv = 1;
         end else if ($urandom_range(7) == 0) begin
            cv = 1;
         end
         cm = ($urandom_range(24) == 0);
         cyc(r, av, ard, cv, ctag, $urandom, cm,
             $urandom);
      end

      // Drain with a bounded budget
      for (int n = 0; n < 300 && rob.size() > 0; n++) begin
         idx = -1;
         foreach (rob[i]) if (idx < 0 && !rob[i].done) idx = i;
         if (idx >= 0) cdb(5'(rob[idx].tag), $urandom, 0, 0);
         else idle();
      end
      chk("drain_left", 64'(rob.size()), 0);
      repeat (3) idle();
      chk("exp_left", 64'(expq.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
